jpeg_vlx_byte_writer: RTL and testbench

- Downstream of the VLX bit-packer in the OR1200 JPEG path.
- Accepts packed entropy-coded bytes one per handshake and inserts a 0x00 after every 0xFF (JPEG byte stuffing).
- Buffers the resulting byte stream in a small FIFO.
- Writes each byte to memory as a Wishbone master single-byte write at an auto-incrementing address, so the CPU stalls only while the FIFO is full.

---
 rtl/jpeg_vlx_byte_writer.sv | 221 ++++++++++++++++++++++
 tb/tb_jpeg_vlx_byte_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_vlx_byte_writer.sv
// jpeg_vlx_byte_writer
//   Takes entropy-coded bytes from the VLX bit-packer, optionally inserts a
//   0x00 after every 0xFF (JPEG byte stuffing), buffers them in a small FIFO
//   and writes each byte to memory as a Wishbone single-byte write at an
//   auto-incrementing address.
//
//   Build option: define JPEG_BYTE_STUFF_EN to enable 0xFF/0x00 stuffing.
//   Without it, bytes pass through unchanged.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   byte_valid_i/byte_i packer byte offer
//   byte_ready_o        byte accepted when valid and ready are both high
//   set_addr_i/addr_i   load start address (legal only when idle and empty)
//   cur_addr_o          address of the next byte to be written
//   busy_o              FIFO non-empty or bus cycle in progress
//   err_o               sticky bus error or illegal address load
//   wb_*                Wishbone master write port (big-endian byte lanes)
module jpeg_vlx_byte_writer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   input  logic        set_addr_i,
   input  logic [31:0] addr_i,
   output logic [31:0] cur_addr_o,
   output logic        busy_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int unsigned CW = AW + 1;

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [7:0]      r_mem [DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_nxt;
   logic [CW-1:0]   w_free_nxt;
   logic            r_ready;
   logic            r_busy;
   logic            r_err;
   logic [31:0]     r_cur_addr;

   logic            r_cyc;
   logic            r_stb;
   logic [31:0]     r_adr;
   logic [3:0]      r_sel;
   logic [31:0]     r_dat;
   logic            w_cyc_nxt;
   logic            w_stb_nxt;
   logic [31:0]     w_adr_nxt;
   logic [3:0]      w_sel_nxt;
   logic [31:0]     w_dat_nxt;

   logic            w_push;
   logic            w_stuff;
   logic            w_pop;
   logic            w_bus_done;
   logic            w_set_ok;
   logic [7:0]      w_head;

   assign w_push     = byte_valid_i & r_ready;
   assign w_bus_done = (r_state == S_REQ) & (wb_ack_i | wb_err_i);
   // An errored byte is dropped, so every completed bus cycle pops.
   assign w_pop      = w_bus_done;
   assign w_set_ok   = set_addr_i & (r_state == S_IDLE) & (r_count == '0);
   assign w_head     = r_mem[r_rd_ptr];

`ifdef JPEG_BYTE_STUFF_EN
   logic [AW-1:0]   w_wr_ptr1;
   assign w_wr_ptr1  = r_wr_ptr + AW'(1);
   assign w_stuff    = w_push & (byte_i == 8'hFF);
`else
   assign w_stuff    = 1'b0;
`endif

   assign w_count_nxt = r_count + CW'(w_push) + CW'(w_stuff) - CW'(w_pop);
   assign w_free_nxt  = CW'(DEPTH) - w_count_nxt;

   // FIFO storage; a stuffed 0xFF fills two consecutive slots at once.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= byte_i;
`ifdef JPEG_BYTE_STUFF_EN
         if (w_stuff) r_mem[w_wr_ptr1] <= 8'h00;
`endif
      end
   end

   // FIFO pointers, occupancy and registered ready/busy flags.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ready  <= 1'b1;
         r_busy   <= 1'b0;
      end else begin
         r_wr_ptr <= r_wr_ptr + AW'(w_push) + AW'(w_stuff);
         r_rd_ptr <= r_rd_ptr + AW'(w_pop);
         r_count  <= w_count_nxt;
`ifdef JPEG_BYTE_STUFF_EN
         r_ready  <= (w_free_nxt >= CW'(2));
`else
         r_ready  <= (w_free_nxt != '0);
`endif
         r_busy   <= (w_count_nxt != '0) | (w_state_nxt == S_REQ);
      end
   end

   // Write address and sticky error flag.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cur_addr <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_set_ok) begin
            r_cur_addr <= addr_i;
            r_err      <= 1'b0;
         end else begin
            if (set_addr_i) r_err <= 1'b1;
            if (w_bus_done) begin
               if (wb_err_i) r_err      <= 1'b1;
               else          r_cur_addr <= r_cur_addr + 32'd1;
            end
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (r_count != '0)         w_state_nxt = S_REQ;
         S_REQ:   if (wb_ack_i | wb_err_i)   w_state_nxt = S_IDLE;
         default:                            w_state_nxt = S_IDLE;
      endcase
   end

   // FSM output logic: next values of the registered bus outputs.
   always_comb begin
      w_cyc_nxt = r_cyc;
      w_stb_nxt = r_stb;
      w_adr_nxt = r_adr;
      w_sel_nxt = r_sel;
      w_dat_nxt = r_dat;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_cyc_nxt = 1'b1;
               w_stb_nxt = 1'b1;
               w_adr_nxt = r_cur_addr;
               w_sel_nxt = 4'b1000 >> r_cur_addr[1:0];
               w_dat_nxt = {4{w_head}};
            end
         end
         S_REQ: begin
            if (wb_ack_i | wb_err_i) begin
               w_cyc_nxt = 1'b0;
               w_stb_nxt = 1'b0;
            end
         end
         default: begin
            w_cyc_nxt = 1'b0;
            w_stb_nxt = 1'b0;
         end
      endcase
   end

   // Bus output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cyc <= 1'b0;
         r_stb <= 1'b0;
         r_adr <= '0;
         r_sel <= '0;
         r_dat <= '0;
      end else begin
         r_cyc <= w_cyc_nxt;
         r_stb <= w_stb_nxt;
         r_adr <= w_adr_nxt;
         r_sel <= w_sel_nxt;
         r_dat <= w_dat_nxt;
      end
   end

   assign byte_ready_o = r_ready;
   assign busy_o       = r_busy;
   assign err_o        = r_err;
   assign cur_addr_o   = r_cur_addr;
   assign wb_cyc_o     = r_cyc;
   assign wb_stb_o     = r_stb;
   assign wb_we_o      = r_cyc;
   assign wb_adr_o     = r_adr;
   assign wb_sel_o     = r_sel;
   assign wb_dat_o     = r_dat;

endmodule

// File: tb/tb_jpeg_vlx_byte_writer.sv
// Testbench for jpeg_vlx_byte_writer: a Wishbone slave model checks every
// write against a queue of expected bytes and a model write address.
module tb_jpeg_vlx_byte_writer;

`ifdef JPEG_BYTE_STUFF_EN
   localparam bit STUFF = 1'b1;
`else
   localparam bit STUFF = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        byte_valid_i = 1'b0;
   logic [7:0]  byte_i = 8'h00;
   logic        byte_ready_o;
   logic        set_addr_i = 1'b0;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] cur_addr_o;
   logic        busy_o;
   logic        err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic        wb_ack_i;
   logic        wb_err_i;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   logic [31:0] exp_addr = 32'h0;
   bit          hold_ack = 1'b0;
   bit          err_next = 1'b0;
   int          wait_states = 0;

   jpeg_vlx_byte_writer #(.DEPTH(8), .AW(3)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .byte_valid_i (byte_valid_i),
      .byte_i       (byte_i),
      .byte_ready_o (byte_ready_o),
      .set_addr_i   (set_addr_i),
      .addr_i       (addr_i),
      .cur_addr_o   (cur_addr_o),
      .busy_o       (busy_o),
      .err_o        (err_o),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_o     (wb_dat_o),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Wishbone slave: responds after wait_states cycles, checks each write.
   initial begin
      logic [7:0] eb;
      logic [3:0] es;
      int         ws_cnt;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      ws_cnt   = 0;
      forever begin
         @(posedge clk_i); #1;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         if (wb_stb_o && !rst_i && !hold_ack) begin
            if (ws_cnt < wait_states) ws_cnt++;
            else begin
               ws_cnt = 0;
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL bus_unexpected: got adr=%h dat=%h, required no transfer",
                           wb_adr_o, wb_dat_o);
               end else begin
                  eb = exp_q.pop_front();
                  es = 4'b1000 >> exp_addr[1:0];
                  if ({wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !==
                      {1'b1, 1'b1, exp_addr, es, {4{eb}}}) begin
                     n_fail++;
                     $display("FAIL bus_write: got cyc=%b we=%b adr=%h sel=%b dat=%h, required cyc=1 we=1 adr=%h sel=%b dat=%h",
                              wb_cyc_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
                              exp_addr, es, {4{eb}});
                  end
               end
               if (err_next) begin
                  wb_err_i = 1'b1;
                  err_next = 1'b0;
               end else begin
                  wb_ack_i = 1'b1;
                  exp_addr = exp_addr + 32'd1;
               end
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      int t;
      t = 0;
      while (!byte_ready_o && t < 100) begin
         @(posedge clk_i); #1;
         t++;
      end
      if (!byte_ready_o) begin
         n_cmp++;
         n_fail++;
         $display("FAIL push_timeout: byte %h never accepted, ready=%b required 1", b, byte_ready_o);
         return;
      end
      byte_valid_i = 1'b1;
      byte_i       = b;
      exp_q.push_back(b);
      if (STUFF && b == 8'hFF) exp_q.push_back(8'h00);
      @(posedge clk_i); #1;
      byte_valid_i = 1'b0;
   endtask

   task automatic load_addr(input logic [31:0] a);
      set_addr_i = 1'b1;
      addr_i     = a;
      @(posedge clk_i); #1;
      set_addr_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin
         @(posedge clk_i); #1;
         t++;
      end while ((busy_o || wb_cyc_o || exp_q.size() != 0) && t < 300);
      n_cmp++;
      if (busy_o || wb_cyc_o || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: busy=%b cyc=%b pending=%0d, required 0 0 0",
                  tag, busy_o, wb_cyc_o, exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      n_cmp++;
      if ({byte_ready_o, busy_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b100000) begin
         n_fail++;
         $display("FAIL reset_flags: got rdy,busy,err,cyc,stb,we=%b required 100000",
                  {byte_ready_o, busy_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o});
      end
      n_cmp++;
      if ({cur_addr_o, wb_adr_o, wb_sel_o, wb_dat_o} !== 100'h0) begin
         n_fail++;
         $display("FAIL reset_data: got cur=%h adr=%h sel=%b dat=%h required all zero",
                  cur_addr_o, wb_adr_o, wb_sel_o, wb_dat_o);
      end
      rst_i = 1'b0;
      @(posedge clk_i); #1;
   endtask

   task automatic test_single();
      wait_states = 1;
      load_addr(32'h0000_1002);
      exp_addr = 32'h0000_1002;
      push_byte(8'h12);
      n_cmp++;
      if ({busy_o, wb_stb_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL single_accept: got busy=%b stb=%b required busy=1 stb=0", busy_o, wb_stb_o);
      end
      @(posedge clk_i); #1;
      n_cmp++;
      if ({wb_stb_o, wb_adr_o, wb_sel_o, wb_dat_o} !== {1'b1, 32'h0000_1002, 4'b0010, 32'h1212_1212}) begin
         n_fail++;
         $display("FAIL single_issue: got stb=%b adr=%h sel=%b dat=%h required 1 00001002 0010 12121212",
                  wb_stb_o, wb_adr_o, wb_sel_o, wb_dat_o);
      end
      wait_idle("single");
      @(posedge clk_i); #1;
      n_cmp++;
      if ({cur_addr_o, busy_o} !== {32'h0000_1003, 1'b0}) begin
         n_fail++;
         $display("FAIL single_after: got cur=%h busy=%b required 00001003 0", cur_addr_o, busy_o);
      end
      wait_states = 0;
   endtask

   task automatic test_stuff();
      logic [31:0] want;
      want = STUFF ? 32'h0000_2002 : 32'h0000_2001;
      load_addr(32'h0000_2000);
      exp_addr = 32'h0000_2000;
      push_byte(8'hFF);
      wait_idle("stuff");
      n_cmp++;
      if (cur_addr_o !== want) begin
         n_fail++;
         $display("FAIL stuff_addr: got cur=%h required %h", cur_addr_o, want);
      end
   endtask

   task automatic test_full();
      int          n_fill;
      logic [31:0] want;
      n_fill   = STUFF ? 7 : 8;
      want     = 32'h0000_4000 + 32'(n_fill);
      load_addr(32'h0000_4000);
      exp_addr = 32'h0000_4000;
      hold_ack = 1'b1;
      for (int i = 1; i <= n_fill; i++) begin
         if (i == n_fill) begin
            n_cmp++;
            if (byte_ready_o !== 1'b1) begin
               n_fail++;
               $display("FAIL full_ready_before: got ready=%b required 1 at count %0d", byte_ready_o, i - 1);
            end
         end
         push_byte(8'(i));
      end
      n_cmp++;
      if (byte_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ready_low: got ready=%b required 0", byte_ready_o);
      end
      // Offer a byte while full; it must be ignored.
      byte_valid_i = 1'b1;
      byte_i       = 8'h55;
      repeat (2) begin @(posedge clk_i); #1; end
      byte_valid_i = 1'b0;
      n_cmp++;
      if (byte_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL full_hold: got ready=%b required 0", byte_ready_o);
      end
      hold_ack = 1'b0;
      wait_idle("full");
      n_cmp++;
      if (cur_addr_o !== want) begin
         n_fail++;
         $display("FAIL full_addr: got cur=%h required %h", cur_addr_o, want);
      end
   endtask

   task automatic test_bus_error();
      load_addr(32'h0000_3000);
      exp_addr = 32'h0000_3000;
      err_next = 1'b1;
      push_byte(8'hA0);
      push_byte(8'hA1);
      push_byte(8'hA2);
      wait_idle("err");
      n_cmp++;
      if ({err_o, cur_addr_o} !== {1'b1, 32'h0000_3002}) begin
         n_fail++;
         $display("FAIL err_flag: got err=%b cur=%h required 1 00003002", err_o, cur_addr_o);
      end
      load_addr(32'h0000_5000);
      exp_addr = 32'h0000_5000;
      n_cmp++;
      if ({err_o, cur_addr_o} !== {1'b0, 32'h0000_5000}) begin
         n_fail++;
         $display("FAIL err_clear: got err=%b cur=%h required 0 00005000", err_o, cur_addr_o);
      end
   endtask

   task automatic test_illegal_addr();
      hold_ack = 1'b1;
      push_byte(8'h33);
      load_addr(32'h0000_9999);
      n_cmp++;
      if ({err_o, cur_addr_o} !== {1'b1, 32'h0000_5000}) begin
         n_fail++;
         $display("FAIL illegal_addr: got err=%b cur=%h required 1 00005000", err_o, cur_addr_o);
      end
      hold_ack = 1'b0;
      wait_idle("illegal");
      n_cmp++;
      if (cur_addr_o !== 32'h0000_5001) begin
         n_fail++;
         $display("FAIL illegal_after: got cur=%h required 00005001", cur_addr_o);
      end
   endtask

   task automatic test_reset_mid();
      load_addr(32'h0000_6000);
      exp_addr = 32'h0000_6000;
      hold_ack = 1'b1;
      push_byte(8'h44);
      push_byte(8'h45);
      @(posedge clk_i); #1;
      n_cmp++;
      if ({wb_cyc_o, wb_stb_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL rstmid_req: got cyc=%b stb=%b required 11", wb_cyc_o, wb_stb_o);
      end
      #2 rst_i = 1'b1;
      #1;
      n_cmp++;
      if ({wb_cyc_o, wb_stb_o, byte_ready_o, busy_o, cur_addr_o} !== {4'b0010, 32'h0}) begin
         n_fail++;
         $display("FAIL rstmid_async: got cyc=%b stb=%b rdy=%b busy=%b cur=%h required 0 0 1 0 00000000",
                  wb_cyc_o, wb_stb_o, byte_ready_o, busy_o, cur_addr_o);
      end
      exp_q.delete();
      hold_ack = 1'b0;
      exp_addr = 32'h0;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      // FIFO contents were discarded: only the new byte may appear on the bus.
      push_byte(8'h5A);
      wait_idle("rstmid");
      n_cmp++;
      if (cur_addr_o !== 32'h0000_0001) begin
         n_fail++;
         $display("FAIL rstmid_after: got cur=%h required 00000001", cur_addr_o);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stuff();
      test_full();
      test_bus_error();
      test_illegal_addr();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
